// File: rtl/a_line_acq_multi_if.sv
// ADC sample stream in, A-line RAM write stream out; master is the acquisition block's view.
interface a_line_acq_multi_if #(
  parameter int NCH    = 1,
  parameter int DATA_W = 14,
  parameter int ADDR_W = 11
);
  logic [NCH*DATA_W-1:0] adc_data;
  logic                  adc_valid;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [NCH*DATA_W-1:0] wr_data;

  modport master (
    input  adc_data, adc_valid,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output adc_data, adc_valid,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/a_line_acq_multi.sv
// Multi-channel A-line capture: trigger edge, skip trig_delay samples, write NSAMPLES to RAM (TEST_PATTERN_EN adds test pattern).
// Latency: adc_valid to wr_en 1 cycle; aline_done 1 cycle after the DONE state.
// Backpressure: none; the stream is paced by adc_valid only, gaps simply stall DELAY/ACQ.
module a_line_acq_multi #(
  parameter int NCH      = 1,
  parameter int DATA_W   = 14,
  parameter int NSAMPLES = 1170,
  parameter int ADDR_W   = 11,
  parameter int DLY_W    = 11,
  parameter int CNT_W    = 16
) (
  input  logic                clk_system,
  input  logic                global_reset,
  input  logic                enable,
  input  logic                trigger,
  input  logic [DLY_W-1:0]    trig_delay,
  input  logic                clear_flags,
  input  logic                test_mode,
  a_line_acq_multi_if.master  bus,
  output logic                aline_done,
  output logic [CNT_W-1:0]    aline_count,
  output logic                acq_busy,
  output logic                missed_trig,
  output logic [7:0]          missed_count
);
  localparam int DW = NCH * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NSAMPLES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, ACQ, DONE} state_t;

  state_t            state, state_nxt;
  logic              trig_q;
  logic              trig_edge;
  logic              start;
  logic              miss;
  logic              wr_fire;
  logic [DLY_W-1:0]  dly_cnt;
  logic [ADDR_W-1:0] idx;
  logic [DW-1:0]     wr_sel;

  assign trig_edge = trigger & ~trig_q;
  assign acq_busy  = (state != IDLE);
  assign start     = (state == IDLE) & trig_edge & enable;
  assign miss      = trig_edge & acq_busy;

  always_ff @(posedge clk_system or posedge global_reset) begin
    if (global_reset) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_fire   = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = (trig_delay == '0) ? ACQ : DELAY;
      DELAY: if (bus.adc_valid && dly_cnt == DLY_W'(1)) state_nxt = ACQ;
      ACQ: begin
        if (bus.adc_valid) begin
          wr_fire = 1'b1;
          if (idx == LAST_IDX) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef TEST_PATTERN_EN
  always_comb begin
    wr_sel = bus.adc_data;
    if (test_mode) begin
      for (int c = 0; c < NCH; c++) wr_sel[c*DATA_W +: DATA_W] = DATA_W'(int'(idx) + c);
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign wr_sel = bus.adc_data;
`endif

  // trig_q resets high so a trigger already high at reset release is not seen as an edge
  always_ff @(posedge clk_system or posedge global_reset) begin
    if (global_reset) begin
      trig_q       <= 1'b1;
      dly_cnt      <= '0;
      idx          <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      aline_done   <= 1'b0;
      aline_count  <= '0;
      missed_trig  <= 1'b0;
      missed_count <= '0;
    end else begin
      trig_q <= trigger;

      if (start)                               dly_cnt <= trig_delay;
      else if (state == DELAY && bus.adc_valid) dly_cnt <= dly_cnt - DLY_W'(1);

      if (state != ACQ) idx <= '0;
      else if (wr_fire) idx <= idx + ADDR_W'(1);

      bus.wr_en <= wr_fire;
      if (wr_fire) begin
        bus.wr_addr <= idx;
        bus.wr_data <= wr_sel;
      end

      aline_done <= (state == DONE);
      if (state == DONE) aline_count <= aline_count + CNT_W'(1);

      // a clear in the same cycle as a miss wins and the miss is dropped
      if (clear_flags) begin
        missed_trig  <= 1'b0;
        missed_count <= '0;
      end else if (miss) begin
        missed_trig <= 1'b1;
        if (missed_count != 8'hFF) missed_count <= missed_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_a_line_acq_multi.sv
// Bench for a_line_acq_multi: random ADC streams checked against a sample-list reference model.
module tb_a_line_acq_multi;
  localparam int NCH = 2, DATA_W = 14, NSAMPLES = 8, ADDR_W = 11, DLY_W = 11, CNT_W = 16;
  localparam int DW = NCH * DATA_W;

  logic clk_system = 1'b0;
  always #5 clk_system = ~clk_system;

  logic             global_reset, enable, trigger, clear_flags, test_mode;
  logic [DLY_W-1:0] trig_delay;
  logic             aline_done, acq_busy, missed_trig;
  logic [CNT_W-1:0] aline_count;
  logic [7:0]       missed_count;

  a_line_acq_multi_if #(.NCH(NCH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  a_line_acq_multi #(
    .NCH(NCH), .DATA_W(DATA_W), .NSAMPLES(NSAMPLES),
    .ADDR_W(ADDR_W), .DLY_W(DLY_W), .CNT_W(CNT_W)
  ) dut (
    .clk_system(clk_system), .global_reset(global_reset), .enable(enable),
    .trigger(trigger), .trig_delay(trig_delay), .clear_flags(clear_flags),
    .test_mode(test_mode), .bus(bus), .aline_done(aline_done),
    .aline_count(aline_count), .acq_busy(acq_busy), .missed_trig(missed_trig),
    .missed_count(missed_count)
  );

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  int done_cnt = 0;
  int wbase, dbase;
  logic [ADDR_W-1:0] wq_addr[$];
  logic [DW-1:0]     wq_data[$];
  logic [DW-1:0]     samples[$];

  // Write/done monitor, sampled away from the active edge
  always @(negedge clk_system) begin
    if (bus.wr_en) begin
      wq_addr.push_back(bus.wr_addr);
      wq_data.push_back(bus.wr_data);
    end
    if (aline_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk_system);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int i);
    logic [DW-1:0] p;
    p = '0;
    for (int c = 0; c < NCH; c++) p[c*DATA_W +: DATA_W] = DATA_W'(i + c);
    return p;
  endfunction

  // pct < 0 selects a valid on every second cycle
  task automatic drive_sample(input int pct, input int n);
    if (pct < 0) bus.adc_valid = n[0];
    else         bus.adc_valid = ($urandom_range(99) < pct);
    bus.adc_data = DW'($urandom);
    if (bus.adc_valid) samples.push_back(bus.adc_data);
  endtask

  task automatic start_edge(input int dly);
    trigger = 1'b0;
    bus.adc_valid = 1'b0;
    tick();
    trigger = 1'b1;
    trig_delay = DLY_W'(dly);
    tick();
    samples.delete();
    wbase = wq_addr.size();
    dbase = done_cnt;
  endtask

  // Reference: the written stream is the valid samples after the edge, minus the first dly
  task automatic stream_check(input string tag, input int dly, input int pct,
                              input bit tmode, input bit inject);
    int n = 0;
    int ph = 0;
    logic [DW-1:0] exp_d;
    test_mode = tmode;
    while (samples.size() < dly + NSAMPLES && n < 2000) begin
      if (inject && ph == 0 && samples.size() >= dly + 3) begin
        trigger = 1'b0;
        ph = 1;
      end else if (ph == 1) begin
        trigger = 1'b1;
        ph = 2;
      end
      drive_sample(pct, n);
      tick();
      n++;
    end
    bus.adc_valid = 1'b0;
    repeat (4) tick();
    check({tag, "_budget"}, n < 2000, 1);
    check({tag, "_nwr"}, wq_addr.size() - wbase, NSAMPLES);
    for (int i = 0; i < NSAMPLES; i++) begin
      if (wbase + i < wq_addr.size() && dly + i < samples.size()) begin
`ifdef TEST_PATTERN_EN
        exp_d = tmode ? pattern(i) : samples[dly + i];
`else
        exp_d = samples[dly + i];
`endif
        check({tag, "_addr"}, wq_addr[wbase + i], i);
        check({tag, "_data"}, wq_data[wbase + i], exp_d);
      end
    end
    exp_count++;
    check({tag, "_done"}, done_cnt - dbase, 1);
    check({tag, "_count"}, aline_count, exp_count);
    check({tag, "_busy"}, acq_busy, 0);
    test_mode = 1'b0;
  endtask

  initial begin
    int n;
    global_reset = 1'b1; enable = 1'b1; trigger = 1'b1; clear_flags = 1'b0;
    test_mode = 1'b0; trig_delay = '0; bus.adc_valid = 1'b0; bus.adc_data = '0;
    repeat (3) tick();
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_done", aline_done, 0);
    check("rst_count", aline_count, 0);
    check("rst_busy", acq_busy, 0);
    check("rst_mtrig", missed_trig, 0);
    check("rst_mcount", missed_count, 0);

    // trigger high through reset release is not an edge
    global_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin drive_sample(100, i); tick(); end
    check("hold_busy", acq_busy, 0);
    check("hold_nwr", wq_addr.size(), 0);

    start_edge(0); stream_check("t1", 0, 100, 1'b0, 1'b0);
    start_edge(3); stream_check("t2", 3, -1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      int d;
      d = $urandom_range(5);
      start_edge(d);
      stream_check("rnd", d, $urandom_range(100, 30), 1'b0, 1'b0);
    end

    enable = 1'b0; trigger = 1'b0; tick();
    trigger = 1'b1; tick(); tick();
    check("dis_busy", acq_busy, 0);
    enable = 1'b1;

    start_edge(1); stream_check("t3", 1, 100, 1'b0, 1'b1);
    check("t3_mtrig", missed_trig, 1);
    check("t3_mcount", missed_count, 1);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    check("clr_mtrig", missed_trig, 0);
    check("clr_mcount", missed_count, 0);

    start_edge(5);
    repeat (260) begin trigger = 1'b0; tick(); trigger = 1'b1; tick(); end
    check("sat_mcount", missed_count, 255);
    check("sat_mtrig", missed_trig, 1);
    check("sat_busy", acq_busy, 1);
    trigger = 1'b0; tick();
    trigger = 1'b1; clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    check("clrwin_mcount", missed_count, 0);
    check("clrwin_mtrig", missed_trig, 0);
    stream_check("sat", 5, 100, 1'b0, 1'b0);

    // reset mid A-line
    start_edge(0);
    n = 0;
    while (wq_addr.size() - wbase < 4 && n < 100) begin drive_sample(100, n); tick(); n++; end
    check("mid_budget", n < 100, 1);
    global_reset = 1'b1; bus.adc_valid = 1'b0;
    @(negedge clk_system);
    check("mid_wr_en", bus.wr_en, 0);
    check("mid_wr_addr", bus.wr_addr, 0);
    check("mid_wr_data", bus.wr_data, 0);
    check("mid_count", aline_count, 0);
    check("mid_busy", acq_busy, 0);
    tick(); global_reset = 1'b0;
    repeat (4) tick();
    check("mid_nodone", done_cnt - dbase, 0);
    exp_count = 0;
    start_edge(2); stream_check("post_rst", 2, 70, 1'b0, 1'b0);

    start_edge(1); stream_check("tpat", 1, 100, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
